fp_float2int: RTL and testbench

Pipelined converter from IEEE-754 binary float (DATA_W/EXP_W format, single precision by default) to a two's-complement signed integer. It rounds to nearest, ties to even, and saturates out-of-range values. It sits beside `fp_add` in the FPU as the float-to-integer path, using the same start/done handshake and the same overflow/underflow/exception flag set. It is fully pipelined: it accepts one operand per cycle and never stalls.

---
 rtl/fp_float2int_pkg.sv | 24 ++
 rtl/fp_align_shift.sv | 56 +++++
 rtl/fp_float2int.sv | 179 +++++++++++++++++
 tb/tb_fp_float2int.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fp_float2int_pkg.sv
// Shared FPU header: operand classification and the format derivations
// (mantissa width including the hidden bit, exponent bias) used by the
// float<->integer paths and fp_add.
package fp_float2int_pkg;

  // Operand class decided once at unpack time and carried down the pipe.
  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,
    CLS_ZERO   = 2'd1,
    CLS_INF    = 2'd2,
    CLS_NAN    = 2'd3
  } fp_class_t;

  // Mantissa width including the hidden bit.
  function automatic int man_width(input int data_w, input int exp_w);
    return data_w - exp_w;
  endfunction

  // Exponent bias, 2^(EXP_W-1)-1.
  function automatic int exp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_align_shift.sv
// Combinational mantissa aligner for the float-to-integer path.
// Ports:
//   man    - mantissa with hidden bit (MAN_W bits)
//   e      - unbiased exponent, signed (E_W bits)
//   mag    - integer magnitude before rounding (INT_W bits, unsigned)
//   guard  - first bit dropped by a right shift
//   sticky - OR of all bits below guard
module fp_align_shift
  import fp_float2int_pkg::*;
#(
  parameter int MAN_W = 24,
  parameter int INT_W = 32,
  parameter int E_W   = 9
) (
  input  logic [MAN_W-1:0]      man,
  input  logic signed [E_W-1:0] e,
  output logic [INT_W-1:0]      mag,
  output logic                  guard,
  output logic                  sticky
);

  logic [2*MAN_W-1:0] rgt;
  int ei;
  int lsh;
  int rsh;

  // The right path shifts the mantissa into a double-width window: the upper
  // half is the integer part, the lower half holds guard and sticky bits.
  // Left shifts beyond INT_W only occur for "big" operands, which the top
  // saturates regardless of mag.
  always_comb begin
    mag    = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    rgt    = '0;
    lsh    = 0;
    rsh    = 0;
    ei     = int'(e);
    if (ei >= MAN_W - 1) begin
      lsh = ei - (MAN_W - 1);
      mag = INT_W'(man) << lsh;
    end else if (ei >= 0) begin
      rsh    = MAN_W - 1 - ei;
      rgt    = {man, {MAN_W{1'b0}}} >> rsh;
      mag    = INT_W'(rgt[2*MAN_W-1:MAN_W]);
      guard  = rgt[MAN_W-1];
      sticky = |rgt[MAN_W-2:0];
    end else if (ei == -1) begin
      guard  = 1'b1;
      sticky = |man[MAN_W-2:0];
    end else begin
      sticky = 1'b1;
    end
  end

endmodule

// File: rtl/fp_float2int.sv
// Four-stage pipelined float-to-integer converter, round to nearest even,
// saturating. Accepts one operand per cycle, never stalls.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   start, op  - operand valid strobe and float operand
//   done       - one-cycle pulse, res and flags valid
//   res        - signed integer result
//   overflow   - finite input out of range, result saturated
//   underflow  - nonzero input rounded to 0
//   exception  - NaN or infinity input
module fp_float2int
  import fp_float2int_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8,
  parameter int INT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] op,
  output logic              done,
  output logic [INT_W-1:0]  res,
  output logic              overflow,
  output logic              underflow,
  output logic              exception
);

  localparam int MAN_W = man_width(DATA_W, EXP_W);
  localparam int BIAS  = exp_bias(EXP_W);
  localparam logic [EXP_W:0]   BIAS_V  = (EXP_W+1)'(BIAS);
  localparam logic [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};

  // Stage 1: unpack and classify
  logic                    sign_c;
  logic [EXP_W-1:0]        exp_c;
  logic [MAN_W-2:0]        frac_c;
  logic signed [EXP_W:0]   e_c;
  fp_class_t               cls_c;

  assign sign_c = op[DATA_W-1];
  assign exp_c  = op[DATA_W-2 -: EXP_W];
  assign frac_c = op[MAN_W-2:0];
  assign e_c    = $signed({1'b0, exp_c} - BIAS_V);

  always_comb begin
    cls_c = CLS_NORMAL;
    if (&exp_c)
      cls_c = (|frac_c) ? CLS_NAN : CLS_INF;
    else if (exp_c == '0)
      cls_c = CLS_ZERO;
  end

  logic                  v1, sign1, nz1, big1;
  fp_class_t             cls1;
  logic [MAN_W-1:0]      man1;
  logic signed [EXP_W:0] e1;

  always_ff @(posedge clk) begin
    if (rst) v1 <= 1'b0;
    else     v1 <= start;
    if (start) begin
      sign1 <= sign_c;
      cls1  <= cls_c;
      nz1   <= |op[DATA_W-2:0];
      big1  <= int'(e_c) >= INT_W;
      man1  <= {1'b1, frac_c};
      e1    <= e_c;
    end
  end

  // Stage 2: align
  logic [INT_W-1:0] mag_a;
  logic             guard_a, sticky_a;

  fp_align_shift #(.MAN_W(MAN_W), .INT_W(INT_W), .E_W(EXP_W+1)) u_align (
    .man   (man1),
    .e     (e1),
    .mag   (mag_a),
    .guard (guard_a),
    .sticky(sticky_a)
  );

  logic             v2, sign2, nz2, big2, guard2, sticky2;
  fp_class_t        cls2;
  logic [INT_W-1:0] mag2;

  // Zeros (incl. flushed subnormals) and specials carry a zero magnitude so
  // they can never round up to a nonzero value.
  always_ff @(posedge clk) begin
    if (rst) v2 <= 1'b0;
    else     v2 <= v1;
    if (v1) begin
      sign2 <= sign1;
      cls2  <= cls1;
      nz2   <= nz1;
      big2  <= big1;
      if (cls1 == CLS_NORMAL) begin
        mag2    <= mag_a;
        guard2  <= guard_a;
        sticky2 <= sticky_a;
      end else begin
        mag2    <= '0;
        guard2  <= 1'b0;
        sticky2 <= 1'b0;
      end
    end
  end

  // Stage 3: round to nearest, ties to even
  logic [INT_W-1:0] mag_r_c;
  assign mag_r_c = mag2 + INT_W'(guard2 & (sticky2 | mag2[0]));

  logic             v3, sign3, big3, uf3;
  fp_class_t        cls3;
  logic [INT_W-1:0] mag_r3;

  always_ff @(posedge clk) begin
    if (rst) v3 <= 1'b0;
    else     v3 <= v2;
    if (v2) begin
      sign3  <= sign2;
      cls3   <= cls2;
      big3   <= big2;
      mag_r3 <= mag_r_c;
      uf3    <= nz2 && (mag_r_c == '0) && (cls2 != CLS_NAN) && (cls2 != CLS_INF);
    end
  end

  // Stage 4: sign, saturate, pack. A negative result may reach 2^(INT_W-1)
  // exactly because INT_MIN is representable.
  logic [INT_W-1:0] res_c;
  logic             ov_c, uf_c, ex_c;

  always_comb begin
    res_c = sign3 ? (-mag_r3) : mag_r3;
    ov_c  = 1'b0;
    uf_c  = uf3;
    ex_c  = 1'b0;
    if (cls3 == CLS_NAN) begin
      res_c = INT_MAX;
      ex_c  = 1'b1;
      uf_c  = 1'b0;
    end else if (cls3 == CLS_INF) begin
      res_c = sign3 ? INT_MIN : INT_MAX;
      ex_c  = 1'b1;
      uf_c  = 1'b0;
    end else if (!sign3 && (big3 || mag_r3 > INT_MAX)) begin
      res_c = INT_MAX;
      ov_c  = 1'b1;
      uf_c  = 1'b0;
    end else if (sign3 && (big3 || mag_r3 > INT_MIN)) begin
      res_c = INT_MIN;
      ov_c  = 1'b1;
      uf_c  = 1'b0;
    end
  end

  // Outputs hold their last value between done pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      done      <= 1'b0;
      res       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      exception <= 1'b0;
    end else begin
      done <= v3;
      if (v3) begin
        res       <= res_c;
        overflow  <= ov_c;
        underflow <= uf_c;
        exception <= ex_c;
      end
    end
  end

endmodule

// File: tb/tb_fp_float2int.sv
// Scoreboard bench for fp_float2int: expected results are queued when an
// operand is issued and compared, with latency, when done pulses.
module tb_fp_float2int;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] op;
  logic        done;
  logic [31:0] res;
  logic        overflow, underflow, exception;

  fp_float2int #(.DATA_W(32), .EXP_W(8), .INT_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .done     (done),
    .res      (res),
    .overflow (overflow),
    .underflow(underflow),
    .exception(exception)
  );

  always #5 clk = ~clk;

  // flags packed as {overflow, underflow, exception}
  typedef struct {
    logic [31:0] op;
    logic [31:0] res;
    logic [2:0]  flags;
  } vec_t;

  typedef struct {
    logic [31:0] op;
    logic [31:0] res;
    logic [2:0]  flags;
    int          due;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cycle = 0;
  int   n_issued = 0;
  int   n_done = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Issue one operand on the next rising edge and queue its expected result.
  task automatic applyStimulus(input vec_t v);
    exp_t x;
    x.op    = v.op;
    x.res   = v.res;
    x.flags = v.flags;
    x.due   = cycle + 4;
    start = 1'b1;
    op    = v.op;
    sb.push_back(x);
    n_issued++;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Monitor: every done must match the oldest outstanding operand.
  always @(negedge clk) begin
    exp_t x;
    if (done) begin
      n_done++;
      checkOutput("done_has_pending", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        x = sb.pop_front();
        checkOutput($sformatf("res_%08h", x.op), 64'(res), 64'(x.res));
        checkOutput($sformatf("flags_%08h", x.op), 64'({overflow, underflow, exception}), 64'(x.flags));
        checkOutput($sformatf("latency_%08h", x.op), 64'(cycle), 64'(x.due));
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op    = '0;

    vecs.push_back('{32'h40490FDB, 32'h00000003, 3'b000});
    vecs.push_back('{32'h40200000, 32'h00000002, 3'b000});
    vecs.push_back('{32'h40600000, 32'h00000004, 3'b000});
    vecs.push_back('{32'hBFC00000, 32'hFFFFFFFE, 3'b000});
    vecs.push_back('{32'h3F000000, 32'h00000000, 3'b010});
    vecs.push_back('{32'h4F000000, 32'h7FFFFFFF, 3'b100});
    vecs.push_back('{32'hCF000000, 32'h80000000, 3'b000});
    vecs.push_back('{32'h4EFFFFFF, 32'h7FFFFF80, 3'b000});
    vecs.push_back('{32'h7FC00000, 32'h7FFFFFFF, 3'b001});
    vecs.push_back('{32'hFF800000, 32'h80000000, 3'b001});
    vecs.push_back('{32'h00000001, 32'h00000000, 3'b010});
    vecs.push_back('{32'h80000000, 32'h00000000, 3'b000});
    vecs.push_back('{32'h3F800000, 32'h00000001, 3'b000});
    vecs.push_back('{32'h3FC00000, 32'h00000002, 3'b000});
    vecs.push_back('{32'h3F400000, 32'h00000001, 3'b000});
    vecs.push_back('{32'h3E800000, 32'h00000000, 3'b010});
    vecs.push_back('{32'h3F000001, 32'h00000001, 3'b000});
    vecs.push_back('{32'h3EFFFFFF, 32'h00000000, 3'b010});
    vecs.push_back('{32'hBF000000, 32'h00000000, 3'b010});
    vecs.push_back('{32'h7F800000, 32'h7FFFFFFF, 3'b001});
    vecs.push_back('{32'h4B000001, 32'h00800001, 3'b000});
    vecs.push_back('{32'hC0200000, 32'hFFFFFFFE, 3'b000});
    vecs.push_back('{32'h4F7FFFFF, 32'h7FFFFFFF, 3'b100});
    vecs.push_back('{32'h5F000000, 32'h7FFFFFFF, 3'b100});
    vecs.push_back('{32'hCF000001, 32'h80000000, 3'b100});

    repeat (3) @(negedge clk);
    checkOutput("reset_done", 64'(done), 64'(0));
    checkOutput("reset_res", 64'(res), 64'(0));
    checkOutput("reset_flags", 64'({overflow, underflow, exception}), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Single operand, then idle: result must hold after done.
    applyStimulus(vecs[0]);
    repeat (7) @(negedge clk);
    checkOutput("hold_res", 64'(res), 64'(3));

    // Back-to-back burst, then the rest with random idle gaps.
    for (int i = 1; i < 12; i++) applyStimulus(vecs[i]);
    for (int i = 12; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    checkOutput("drain_1", 64'(sb.size()), 64'(0));
    repeat (2) @(negedge clk);

    // In-flight ops are discarded by reset; a start during reset is ignored.
    start = 1'b1;
    op = 32'h40490FDB;
    @(negedge clk);
    op = 32'h4F000000;
    @(negedge clk);
    op = 32'hFF800000;
    rst = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("rst_no_done_%0d", k), 64'(done), 64'(0));
      @(negedge clk);
    end
    checkOutput("rst_res", 64'(res), 64'(0));
    checkOutput("rst_flags", 64'({overflow, underflow, exception}), 64'(0));

    applyStimulus(vecs[2]);
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    checkOutput("drain_2", 64'(sb.size()), 64'(0));
    checkOutput("done_count", 64'(n_done), 64'(n_issued));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
